// File: rtl/tte_pkg.sv
// tte_pkg: shared receive states, frame-size limits and pointer-word layout for the TTE fabric datapath.
// No ports; imported by tte_fabric_rx, tte_rx_stats and the pointer-word readers downstream.
package tte_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_DATA, S_DROP, S_DRAIN} state_t;
  localparam logic [11:0] MIN_FRAME = 12'd60;
  localparam logic [11:0] MAX_FRAME = 12'd1518;
  localparam logic [11:0] BP_THRESH = 12'd1536;
  localparam int PTR_LEN_W = 11;
  localparam int PTR_ERR_BIT = 11;
  localparam int PTR_PMAP_LSB = 12;
  function automatic logic [15:0] ptr_word(input logic [3:0] pmap, input logic err, input logic [PTR_LEN_W-1:0] len);
    logic [15:0] w;
    w = '0;
    w[PTR_PMAP_LSB +: 4] = pmap;
    w[PTR_ERR_BIT] = err;
    w[PTR_LEN_W-1:0] = len;
    return w;
  endfunction
endpackage

// File: rtl/tte_rx_stats.sv
// tte_rx_stats: saturating receive statistics, present only when TTE_RX_STATS_EN is defined.
// Ports: clk, rst (sync, active-high); i_frame_inc/i_drop_inc/i_trunc_inc event strobes;
// o_frame_cnt[31:0], o_drop_cnt[15:0], o_trunc_cnt[15:0] counters that stick at all-ones.
`ifdef TTE_RX_STATS_EN
module tte_rx_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_inc,
  input  logic        i_drop_inc,
  input  logic        i_trunc_inc,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_trunc_cnt
);
  logic [31:0] r_frame;
  logic [15:0] r_drop, r_trunc;
  always_ff @(posedge clk)
    if (rst) begin
      r_frame <= '0;
      r_drop  <= '0;
      r_trunc <= '0;
    end else begin
      if (i_frame_inc && !(&r_frame)) r_frame <= r_frame + 32'd1;
      if (i_drop_inc && !(&r_drop)) r_drop <= r_drop + 16'd1;
      if (i_trunc_inc && !(&r_trunc)) r_trunc <= r_trunc + 16'd1;
    end
  assign o_frame_cnt = r_frame;
  assign o_drop_cnt  = r_drop;
  assign o_trunc_cnt = r_trunc;
endmodule
`endif

// File: rtl/tte_fabric_rx.sv
// tte_fabric_rx: fabric frame receiver; parses the 2-byte header, admits or drops the frame,
// streams frame bytes to the data buffer and posts one pointer word per accepted frame.
// Ports: clk, rst (sync, active-high); sof/dv/data fabric byte stream in;
// dfifo_wr/dfifo_din data-buffer writes, dfifo_space buffer free bytes;
// ptr_fifo_wr/ptr_fifo_din {portmap,err,len} pointer writes, ptr_fifo_full; bp registered backpressure.
// Defining TTE_RX_STATS_EN adds rx_frame_cnt, rx_drop_cnt, rx_trunc_cnt.
module tte_fabric_rx
  import tte_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        dv,
  input  logic [7:0]  data,
  output logic        dfifo_wr,
  output logic [7:0]  dfifo_din,
  input  logic [11:0] dfifo_space,
  output logic        ptr_fifo_wr,
  output logic [15:0] ptr_fifo_din,
  input  logic        ptr_fifo_full,
  output logic        bp
`ifdef TTE_RX_STATS_EN
  ,
  output logic [31:0] rx_frame_cnt,
  output logic [15:0] rx_drop_cnt,
  output logic [15:0] rx_trunc_cnt
`endif
);
  state_t r_state, w_next;
  logic [3:0] r_pmap, r_lhi;
  logic [PTR_LEN_W-1:0] r_len, r_cnt;
  logic r_pend, r_dfifo_wr, r_ptr_wr, r_bp;
  logic [7:0] r_dfifo_din;
  logic [15:0] r_ptr_din;
  logic w_hdr0, w_byte, w_trunc, w_admit;
  logic [11:0] w_flen;
  assign w_hdr0  = sof & dv;
  assign w_flen  = {r_lhi, data} - 12'd2;
  assign w_admit = (r_pmap != 4'd0) && (w_flen >= MIN_FRAME) && (w_flen <= MAX_FRAME) &&
                   (dfifo_space >= w_flen) && !ptr_fifo_full;
  assign w_byte  = (r_state == S_DATA) && dv && !sof;
  // Leaving DATA early: dv dropped, or a new sof overlapping the unfinished frame.
  assign w_trunc = (r_state == S_DATA) && (!dv || sof);
  always_ff @(posedge clk)
    r_state <= rst ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_hdr0 ? S_HDR1 : S_IDLE;
      S_HDR1:  w_next = !dv ? S_IDLE : w_admit ? S_DATA : S_DROP;
      S_DATA:  w_next = !dv ? S_IDLE : sof ? S_HDR1 : (r_cnt == 11'd1) ? S_DRAIN : S_DATA;
      default: w_next = !dv ? S_IDLE : w_hdr0 ? S_HDR1 : r_state;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_pmap      <= '0;
      r_lhi       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_dfifo_wr  <= 1'b0;
      r_dfifo_din <= '0;
      r_ptr_wr    <= 1'b0;
      r_ptr_din   <= '0;
      r_bp        <= 1'b1;
    end else begin
      r_bp       <= (dfifo_space < BP_THRESH) | ptr_fifo_full;
      r_dfifo_wr <= w_byte;
      if (w_byte) r_dfifo_din <= data;
      if (w_hdr0 && r_state != S_HDR1) begin
        r_pmap <= data[3:0];
        r_lhi  <= data[7:4];
      end
      if (r_state == S_HDR1 && dv) begin
        r_len <= w_flen[PTR_LEN_W-1:0];
        r_cnt <= w_flen[PTR_LEN_W-1:0];
      end
      if (w_byte) r_cnt <= r_cnt - 11'd1;
      // A completed frame posts its pointer one cycle after its last data write;
      // a truncation posts immediately, which is already one cycle after its last write.
      r_pend    <= w_byte && (r_cnt == 11'd1);
      r_ptr_wr  <= r_pend | w_trunc;
      r_ptr_din <= r_pend ? ptr_word(r_pmap, 1'b0, r_len) :
                   w_trunc ? ptr_word(r_pmap, 1'b1, r_len - r_cnt) : r_ptr_din;
    end
  assign dfifo_wr     = r_dfifo_wr;
  assign dfifo_din    = r_dfifo_din;
  assign ptr_fifo_wr  = r_ptr_wr;
  assign ptr_fifo_din = r_ptr_din;
  assign bp           = r_bp;
`ifdef TTE_RX_STATS_EN
  tte_rx_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .i_frame_inc (r_ptr_wr & ~r_ptr_din[PTR_ERR_BIT]),
    .i_drop_inc  ((r_state == S_HDR1) && dv && !w_admit),
    .i_trunc_inc (r_ptr_wr & r_ptr_din[PTR_ERR_BIT]),
    .o_frame_cnt (rx_frame_cnt),
    .o_drop_cnt  (rx_drop_cnt),
    .o_trunc_cnt (rx_trunc_cnt)
  );
`endif
endmodule

// File: tb/tb_tte_fabric_rx.sv
// tb_tte_fabric_rx: randomized self-checking bench for tte_fabric_rx against a frame-level reference model.
module tb_tte_fabric_rx;
  typedef struct { logic [7:0] b; int c; } exp_t;
  logic clk = 1'b0, rst = 1'b1, sof = 1'b0, dv = 1'b0;
  logic [7:0] data = 8'd0;
  logic [11:0] dfifo_space = 12'hFFF;
  logic ptr_fifo_full = 1'b0;
  logic dfifo_wr, ptr_fifo_wr, bp;
  logic [7:0] dfifo_din;
  logic [15:0] ptr_fifo_din;
`ifdef TTE_RX_STATS_EN
  logic [31:0] rx_frame_cnt;
  logic [15:0] rx_drop_cnt, rx_trunc_cnt;
`endif
  int n_chk = 0, n_err = 0, cyc = 0, last_wr = -10, n_wr = 0, n_ptr = 0;
  int m_frames = 0, m_drops = 0, m_truncs = 0;
  logic [15:0] last_ptr = 16'd0;
  logic bp_exp = 1'b1;
  exp_t exp_d[$];
  logic [15:0] exp_p[$];

  tte_fabric_rx dut (
    .clk           (clk),
    .rst           (rst),
    .sof           (sof),
    .dv            (dv),
    .data          (data),
    .dfifo_wr      (dfifo_wr),
    .dfifo_din     (dfifo_din),
    .dfifo_space   (dfifo_space),
    .ptr_fifo_wr   (ptr_fifo_wr),
    .ptr_fifo_din  (ptr_fifo_din),
    .ptr_fifo_full (ptr_fifo_full),
    .bp            (bp)
`ifdef TTE_RX_STATS_EN
    ,
    .rx_frame_cnt  (rx_frame_cnt),
    .rx_drop_cnt   (rx_drop_cnt),
    .rx_trunc_cnt  (rx_trunc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    logic [15:0] p;
    cyc++;
    bp_exp = rst | (dfifo_space < 12'd1536) | ptr_fifo_full;
    #1;
    chk("bp", 32'(bp), 32'(bp_exp));
    if (ptr_fifo_wr === 1'b1) begin
      n_ptr++;
      last_ptr = ptr_fifo_din;
      chk("ptr_expected", 32'(exp_p.size() != 0), 32'd1);
      if (exp_p.size() != 0) begin
        p = exp_p.pop_front();
        chk("ptr_din", 32'(ptr_fifo_din), 32'(p));
        if (p[10:0] != 11'd0) chk("ptr_lat", 32'(cyc), 32'(last_wr + 1));
      end
    end
    if (dfifo_wr === 1'b1) begin
      n_wr++;
      last_wr = cyc;
      chk("dfifo_expected", 32'(exp_d.size() != 0), 32'd1);
      if (exp_d.size() != 0) begin
        e = exp_d.pop_front();
        chk("dfifo_din", 32'(dfifo_din), 32'(e.b));
        chk("dfifo_lat", 32'(cyc), 32'(e.c));
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (cyc > 0) chk("bp_hold", 32'(bp), 32'(bp_exp));
  end

  task automatic send_frame(input logic [3:0] pm, input logic [11:0] len, input int nb, input int pad,
                            input bit chain, input int rst_at, input logic [11:0] sp, input bit full);
    int flen, sent;
    bit adm, cont;
    logic [7:0] b;
    flen = int'(len) - 2;
    adm = (pm != 4'd0) && flen >= 60 && flen <= 1518 && int'(sp) >= flen && !full;
    sent = (nb < flen) ? nb : flen;
    cont = chain && adm && nb < flen;
    if (!adm) m_drops++;
    else if (rst_at < 0) begin
      if (nb >= flen) begin
        exp_p.push_back({pm, 1'b0, 11'(flen)});
        m_frames++;
      end else begin
        exp_p.push_back({pm, 1'b1, 11'(nb)});
        m_truncs++;
      end
    end
    @(negedge clk);
    dfifo_space = sp; ptr_fifo_full = full; sof = 1'b1; dv = 1'b1; data = {len[11:8], pm};
    @(negedge clk);
    sof = 1'b0; data = len[7:0];
    for (int i = 0; i < sent; i++) begin
      b = 8'($urandom);
      @(negedge clk);
      rst = (i == rst_at);
      data = b;
      if (i == rst_at) begin m_frames = 0; m_drops = 0; m_truncs = 0; end
      if (adm && (rst_at < 0 || i < rst_at)) exp_d.push_back('{b, cyc + 1});
    end
    if (nb >= flen)
      for (int i = 0; i < pad; i++) begin
        @(negedge clk);
        rst = 1'b0; data = 8'($urandom);
      end
    if (!cont) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        rst = 1'b0; dv = 1'b0; sof = 1'($urandom); data = 8'($urandom);
      end
      @(negedge clk);
      sof = 1'b0;
      chk("data_drained", 32'(exp_d.size()), 32'd0);
      chk("ptr_drained", 32'(exp_p.size()), 32'd0);
`ifdef TTE_RX_STATS_EN
      chk("st_frames", rx_frame_cnt, 32'(m_frames));
      chk("st_drops", 32'(rx_drop_cnt), 32'(m_drops));
      chk("st_truncs", 32'(rx_trunc_cnt), 32'(m_truncs));
`endif
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int w0, p0;
    repeat (3) @(negedge clk);
    chk("rst_dfifo_wr", 32'(dfifo_wr), 32'd0);
    chk("rst_ptr_wr", 32'(ptr_fifo_wr), 32'd0);
    chk("rst_dfifo_din", 32'(dfifo_din), 32'd0);
    chk("rst_ptr_din", 32'(ptr_fifo_din), 32'd0);
    chk("rst_bp", 32'(bp), 32'd1);
`ifdef TTE_RX_STATS_EN
    chk("rst_st_frames", rx_frame_cnt, 32'd0);
`endif
    rst = 1'b0;
    w0 = n_wr;
    send_frame(4'h3, 12'h342, 832, 5, 1'b0, -1, 12'hFFF, 1'b0);
    chk("caseA_writes", 32'(n_wr - w0), 32'd832);
    chk("caseA_ptr", 32'(last_ptr), 32'h3340);
    w0 = n_wr; p0 = n_ptr;
    send_frame(4'h0, 12'd66, 64, 0, 1'b0, -1, 12'hFFF, 1'b0);
    chk("caseB_writes", 32'(n_wr - w0 + n_ptr - p0), 32'd0);
`ifdef TTE_RX_STATS_EN
    chk("caseB_drop_cnt", 32'(rx_drop_cnt), 32'd1);
`endif
    w0 = n_wr; p0 = n_ptr;
    send_frame(4'h5, 12'd202, 200, 0, 1'b0, -1, 12'd100, 1'b0);
    chk("caseC_writes", 32'(n_wr - w0 + n_ptr - p0), 32'd0);
    chk("caseC_bp", 32'(bp), 32'd1);
    w0 = n_wr;
    send_frame(4'h6, 12'd102, 40, 0, 1'b0, -1, 12'hFFF, 1'b0);
    chk("caseD_writes", 32'(n_wr - w0), 32'd40);
    chk("caseD_ptr", 32'(last_ptr), 32'h6828);
    send_frame(4'h7, 12'd100, 10, 0, 1'b1, -1, 12'hFFF, 1'b0);
    send_frame(4'h9, 12'd80, 78, 2, 1'b0, -1, 12'hFFF, 1'b0);
    chk("caseE_ptr", 32'(last_ptr), 32'h904E);
    w0 = n_wr; p0 = n_ptr;
    send_frame(4'hA, 12'd130, 128, 0, 1'b0, 20, 12'hFFF, 1'b0);
    chk("caseF_writes", 32'(n_wr - w0), 32'd20);
    chk("caseF_ptrs", 32'(n_ptr - p0), 32'd0);
    send_frame(4'hB, 12'd70, 68, 1, 1'b0, -1, 12'hFFF, 1'b0);
    chk("caseF_next_ptr", 32'(last_ptr), 32'hB044);
    send_frame(4'h1, 12'd62, 60, 0, 1'b0, -1, 12'hFFF, 1'b0);
    send_frame(4'h2, 12'd61, 59, 0, 1'b0, -1, 12'hFFF, 1'b0);
    send_frame(4'h3, 12'd1520, 1518, 1, 1'b0, -1, 12'd1518, 1'b0);
    send_frame(4'h4, 12'd1521, 1519, 0, 1'b0, -1, 12'hFFF, 1'b0);
    send_frame(4'h5, 12'd300, 298, 0, 1'b0, -1, 12'd297, 1'b0);
    send_frame(4'h6, 12'd300, 298, 0, 1'b0, -1, 12'hFFF, 1'b1);
    for (int k = 0; k < 25; k++) begin
      logic [3:0] pm;
      logic [11:0] len;
      int flen, nb;
      pm = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      len = 12'($urandom_range(50, 700));
      flen = int'(len) - 2;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, flen - 1)) : flen;
      send_frame(pm, len, nb, int'($urandom_range(0, 4)), (k != 24) && ($urandom_range(0, 1) == 1), -1,
                 12'($urandom_range(0, 4095)), $urandom_range(0, 7) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
